// File: rtl/mem_access_ctrl.sv
// CPU-side controller for an asynchronous RAM handshake (enable/Ready strobes, Clear completion
// flag), splitting dword transfers into two word parts and aborting stuck transfers on timeout.
module mem_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_dtype,
  input  logic [7:0]  cpu_addr,
  input  logic [31:0] cpu_wdata_lo,
  input  logic [31:0] cpu_wdata_hi,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata_lo,
  output logic [31:0] cpu_rdata_hi,
  output logic        mem_enable,
  output logic        mem_r_w,
  output logic        mem_Ready,
  output logic [1:0]  mem_dtype,
  output logic        mem_dwp1,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_data_in,
  input  logic        mem_Clear,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT_LO, WAIT_HI, RELEASE, DROP, DONE
  } state_t;

  state_t        state;
  logic          clr_meta;
  logic          clr_s;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic [1:0]    dtype_q;
  logic [7:0]    addr_q;
  logic [31:0]   wlo_q;
  logic [31:0]   whi_q;
  logic          part2;
  logic          err_q;

  // Outputs are registered on the transition into each state, so enable and Ready
  // are always updated from different states and never toggle on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      clr_meta     <= 1'b0;
      clr_s        <= 1'b0;
      cnt          <= '0;
      rw_q         <= 1'b0;
      dtype_q      <= 2'b00;
      addr_q       <= 8'h00;
      wlo_q        <= 32'h0;
      whi_q        <= 32'h0;
      part2        <= 1'b0;
      err_q        <= 1'b0;
      cpu_busy     <= 1'b0;
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_rdata_lo <= 32'h0;
      cpu_rdata_hi <= 32'h0;
      mem_enable   <= 1'b1;
      mem_r_w      <= 1'b0;
      mem_Ready    <= 1'b0;
      mem_dtype    <= 2'b00;
      mem_dwp1     <= 1'b1;
      mem_addr     <= 8'h00;
      mem_data_in  <= 32'h0;
    end else begin
      clr_meta <= mem_Clear;
      clr_s    <= clr_meta;
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (cpu_req) begin
            rw_q     <= cpu_rw;
            dtype_q  <= cpu_dtype;
            addr_q   <= cpu_addr;
            wlo_q    <= cpu_wdata_lo;
            whi_q    <= cpu_wdata_hi;
            part2    <= 1'b0;
            err_q    <= 1'b0;
            cpu_busy <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          mem_enable  <= 1'b0;
          mem_Ready   <= 1'b0;
          mem_r_w     <= rw_q;
          mem_dtype   <= dtype_q;
          mem_addr    <= addr_q;
          mem_dwp1    <= ~part2;
          mem_data_in <= part2 ? whi_q : wlo_q;
          state       <= STROBE;
        end
        STROBE: begin
          mem_Ready <= 1'b1;
          cnt       <= '0;
          state     <= WAIT_LO;
        end
        // The timeout budget covers both wait states together; only a Clear edge
        // seen in WAIT_HI counts as a successful exit.
        WAIT_LO: begin
          if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
            if (!clr_s) state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (clr_s) begin
            if (!rw_q) begin
              if (part2) begin
                cpu_rdata_hi <= mem_data_out;
              end else begin
                cpu_rdata_lo <= mem_data_out;
                if (dtype_q != 2'b11) cpu_rdata_hi <= 32'h0;
              end
            end
            state <= RELEASE;
          end else if (cnt == CNT_LAST) begin
            err_q <= 1'b1;
            state <= RELEASE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          mem_enable <= 1'b1;
          state      <= DROP;
        end
        DROP: begin
          mem_Ready <= 1'b0;
          if (dtype_q == 2'b11 && !part2 && !err_q) begin
            part2 <= 1'b1;
            state <= SETUP;
          end else begin
            cpu_done <= 1'b1;
            cpu_err  <= err_q;
            state    <= DONE;
          end
        end
        DONE: begin
          cpu_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a byte-array RAM answers the handshake, and a
// 64-bit reference model predicts read data and memory contents from the CPU requests alone.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rw;
  logic [1:0]  cpu_dtype;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata_lo;
  logic [31:0] cpu_wdata_hi;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata_lo;
  logic [31:0] cpu_rdata_hi;
  logic        mem_enable;
  logic        mem_r_w;
  logic        mem_Ready;
  logic [1:0]  mem_dtype;
  logic        mem_dwp1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_Clear;
  logic [31:0] mem_data_out;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_rw       (cpu_rw),
    .cpu_dtype    (cpu_dtype),
    .cpu_addr     (cpu_addr),
    .cpu_wdata_lo (cpu_wdata_lo),
    .cpu_wdata_hi (cpu_wdata_hi),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_rdata_lo (cpu_rdata_lo),
    .cpu_rdata_hi (cpu_rdata_hi),
    .mem_enable   (mem_enable),
    .mem_r_w      (mem_r_w),
    .mem_Ready    (mem_Ready),
    .mem_dtype    (mem_dtype),
    .mem_dwp1     (mem_dwp1),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_Clear    (mem_Clear),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          failures = 0;
  logic [7:0]  ram [256];
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_lo = 32'h0;
  logic [31:0] exp_hi = 32'h0;
  bit          ram_stuck = 1'b0;
  bit          ram_hold = 1'b0;
  int          done_count = 0;
  int          edge_viol = 0;
  bit          rise_q [$];
  logic        prev_ready;
  logic        prev_enable;

  // RAM responder: after a random latency with enable low and Ready high it performs the
  // access and raises Clear, holding data until Ready falls.
  initial begin
    int         n;
    int         ram_cnt;
    logic [7:0] b;
    mem_Clear    = 1'b0;
    mem_data_out = 32'h0;
    ram_cnt      = 0;
    forever begin
      @(negedge clk);
      if (ram_stuck) begin
        mem_Clear = 1'b1;
      end else if (!mem_Ready) begin
        mem_Clear = 1'b0;
        ram_cnt   = $urandom_range(0, 3);
      end else if (!mem_enable && !mem_Clear && !ram_hold) begin
        if (ram_cnt > 0) begin
          ram_cnt--;
        end else begin
          case (mem_dtype)
            2'b00:   begin n = 1; b = mem_addr; end
            2'b01:   begin n = 2; b = mem_addr & 8'hFE; end
            2'b10:   begin n = 4; b = mem_addr & 8'hFC; end
            default: begin n = 4; b = (mem_addr & 8'hF8) | (mem_dwp1 ? 8'h00 : 8'h04); end
          endcase
          if (mem_r_w) begin
            for (int i = 0; i < n; i++) ram[8'(b + i)] = mem_data_in[8*i +: 8];
          end else begin
            mem_data_out = 32'h0;
            for (int i = 0; i < n; i++) mem_data_out[8*i +: 8] = ram[8'(b + i)];
          end
          mem_Clear = 1'b1;
        end
      end
    end
  end

  // Protocol monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (mem_Ready !== prev_ready && mem_enable !== prev_enable) edge_viol++;
      if (mem_Ready === 1'b1 && prev_ready === 1'b0) rise_q.push_back(mem_dwp1);
      if (cpu_done === 1'b1) done_count++;
    end
    prev_ready  = mem_Ready;
    prev_enable = mem_enable;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit rw, input logic [1:0] dt, input logic [7:0] a,
                               input logic [31:0] lo, input logic [31:0] hi);
    cpu_rw       = rw;
    cpu_dtype    = dt;
    cpu_addr     = a;
    cpu_wdata_lo = lo;
    cpu_wdata_hi = hi;
    cpu_req      = 1'b1;
  endtask

  task automatic wait_done(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      cycles++;
      if (cpu_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_Ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Reference: every access is a naturally aligned window of 1/2/4/8 bytes, little endian.
  task automatic ref_window(input logic [1:0] dt, input logic [7:0] a,
                            output logic [7:0] base, output int n);
    case (dt)
      2'b00:   begin n = 1; base = a; end
      2'b01:   begin n = 2; base = {a[7:1], 1'b0}; end
      2'b10:   begin n = 4; base = {a[7:2], 2'b00}; end
      default: begin n = 8; base = {a[7:3], 3'b000}; end
    endcase
  endtask

  task automatic ref_access(input bit rw, input logic [1:0] dt, input logic [7:0] a,
                            input logic [31:0] lo, input logic [31:0] hi);
    logic [7:0]  base;
    int          n;
    logic [63:0] v;
    ref_window(dt, a, base, n);
    v = {hi, lo};
    if (rw) begin
      for (int i = 0; i < n; i++) ref_mem[8'(base + i)] = v[8*i +: 8];
    end else begin
      v = 64'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(base + i)];
      exp_lo = v[31:0];
      exp_hi = v[63:32];
    end
  endtask

  task automatic run_txn(input string tag, input bit rw, input logic [1:0] dt,
                         input logic [7:0] a, input logic [31:0] lo, input logic [31:0] hi);
    bit ok;
    int cyc;
    applyStimulus(rw, dt, a, lo, hi);
    wait_done(ok, cyc);
    ref_access(rw, dt, a, lo, hi);
    checkOutput({tag, "_done"}, 64'(ok), 64'd1);
    checkOutput({tag, "_err"}, 64'(cpu_err), 64'd0);
    checkOutput({tag, "_busy_at_done"}, 64'(cpu_busy), 64'd1);
    checkOutput({tag, "_rdata_lo"}, 64'(cpu_rdata_lo), 64'(exp_lo));
    checkOutput({tag, "_rdata_hi"}, 64'(cpu_rdata_hi), 64'(exp_hi));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {63'h0, cpu_done, cpu_busy}, 64'd0);
  endtask

  initial begin
    bit          ok;
    bit          seen;
    int          cyc;
    int          d0;
    int          mism;
    logic [31:0] lo_before;
    logic [31:0] hi_before;

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'h00;
      ref_mem[i] = 8'h00;
    end
    ram[5]       = 8'hA5;
    ref_mem[5]   = 8'hA5;
    reset        = 1'b1;
    cpu_req      = 1'b0;
    cpu_rw       = 1'b0;
    cpu_dtype    = 2'b00;
    cpu_addr     = 8'h00;
    cpu_wdata_lo = 32'h0;
    cpu_wdata_hi = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_ctrl", {57'h0, mem_enable, mem_Ready, mem_dwp1, mem_r_w, mem_dtype},
                {57'h0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00});
    checkOutput("rst_mem_addr_data", {24'h0, mem_addr, mem_data_in}, 64'h0);
    checkOutput("rst_cpu_flags", {61'h0, cpu_busy, cpu_done, cpu_err}, 64'h0);
    checkOutput("rst_rdata", {cpu_rdata_hi, cpu_rdata_lo}, 64'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_txn("word_wr", 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0);
    run_txn("word_rd", 1'b0, 2'b10, 8'h12, 32'h0, 32'h0);
    checkOutput("word_rd_value", {cpu_rdata_hi, cpu_rdata_lo}, {32'h0, 32'hDEADBEEF});

    rise_q.delete();
    run_txn("dword_wr", 1'b1, 2'b11, 8'h20, 32'h11223344, 32'h55667788);
    checkOutput("dword_ready_count", 64'(rise_q.size()), 64'd2);
    if (rise_q.size() == 2)
      checkOutput("dword_dwp1_order", {62'h0, rise_q[0], rise_q[1]}, 64'b10);
    rise_q.delete();
    run_txn("dword_rd", 1'b0, 2'b11, 8'h20, 32'h0, 32'h0);
    checkOutput("dword_rd_value", {cpu_rdata_hi, cpu_rdata_lo}, 64'h55667788_11223344);
    checkOutput("dword_rd_ready_count", 64'(rise_q.size()), 64'd2);

    run_txn("byte_rd", 1'b0, 2'b00, 8'h05, 32'h0, 32'h0);
    checkOutput("byte_rd_value", 64'(cpu_rdata_lo), 64'h000000A5);

    for (int t = 0; t < 40; t++) begin
      run_txn($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              8'($urandom_range(0, 255)), $urandom(), $urandom());
    end

    // RAM stuck with Clear high: the transfer must give up after the wait budget.
    ram_stuck = 1'b1;
    repeat (4) @(negedge clk);
    lo_before = exp_lo;
    hi_before = exp_hi;
    applyStimulus(1'b0, 2'b10, 8'h10, 32'h0, 32'h0);
    wait_done(ok, cyc);
    checkOutput("to_done", 64'(ok), 64'd1);
    checkOutput("to_latency", 64'(cyc), 64'(TIMEOUT + 5));
    checkOutput("to_err", 64'(cpu_err), 64'd1);
    checkOutput("to_rdata_kept", {cpu_rdata_hi, cpu_rdata_lo}, {hi_before, lo_before});
    checkOutput("to_mem_idle", {62'h0, mem_enable, mem_Ready}, 64'b10);
    @(negedge clk);
    ram_stuck = 1'b0;
    repeat (4) @(negedge clk);

    // A second request during WAIT_LO must be dropped.
    applyStimulus(1'b1, 2'b10, 8'h40, 32'hCAFEF00D, 32'h0);
    d0 = done_count;
    wait_ready(seen);
    checkOutput("busy_ready_seen", 64'(seen), 64'd1);
    applyStimulus(1'b1, 2'b10, 8'h50, 32'h12345678, 32'h0);
    wait_done(ok, cyc);
    ref_access(1'b1, 2'b10, 8'h40, 32'hCAFEF00D, 32'h0);
    checkOutput("busy_done", 64'(ok), 64'd1);
    repeat (30) @(negedge clk);
    checkOutput("busy_single_done", 64'(done_count - d0), 64'd1);
    checkOutput("busy_first_word", {32'h0, ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]},
                64'hCAFEF00D);
    checkOutput("busy_second_ignored",
                {32'h0, ram[8'h53], ram[8'h52], ram[8'h51], ram[8'h50]},
                {32'h0, ref_mem[8'h53], ref_mem[8'h52], ref_mem[8'h51], ref_mem[8'h50]});

    // Reset while the RAM withholds Clear, leaving the FSM in WAIT_HI.
    ram_hold = 1'b1;
    applyStimulus(1'b0, 2'b10, 8'h20, 32'h0, 32'h0);
    wait_ready(seen);
    checkOutput("rstmid_ready_seen", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    checkOutput("rstmid_pre_busy", 64'(cpu_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_mem", {62'h0, mem_enable, mem_Ready}, 64'b10);
    checkOutput("rstmid_cpu", {62'h0, cpu_busy, cpu_done}, 64'b00);
    checkOutput("rstmid_rdata", {cpu_rdata_hi, cpu_rdata_lo}, 64'h0);
    reset    = 1'b0;
    ram_hold = 1'b0;
    exp_lo   = 32'h0;
    exp_hi   = 32'h0;
    d0 = done_count;
    repeat (30) @(negedge clk);
    checkOutput("rstmid_no_done", 64'(done_count - d0), 64'd0);

    run_txn("post_rst_rd", 1'b0, 2'b11, 8'h20, 32'h0, 32'h0);

    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    checkOutput("ram_contents", 64'(mism), 64'd0);
    checkOutput("en_ready_same_edge", 64'(edge_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
